// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   tx_state_t  - transmitter FSM state encoding
//   PAR_EVEN/PAR_ODD - parity-mode constants (XORed into the data parity)
//   frame_len() - serial bits per frame (start + data + parity + stop)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Parity mode: the value XORed into the XOR-reduction of the data bits.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Number of serial bit periods in one frame.
    function automatic int frame_len(input int data_bits,
                                     input int parity_en,
                                     input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps, so consecutive bits
// are exactly CLKS_PER_BIT cycles long with no accumulated drift.
//   clk           in  system clock
//   rst           in  synchronous active-high reset (counter -> 0)
//   i_restart     in  hold counter at 0 (used while the line is idle)
//   o_bit_end     out high on the last cycle of a bit period
//   o_bit_pre_end out high on the second-to-last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_bit_end,
    output logic o_bit_pre_end
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end     = (r_cnt == LAST);
    // Lets registered outputs rise exactly on the final cycle of a bit.
    assign o_bit_pre_end = (r_cnt == PRE);

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with a one-entry holding buffer so frames can
// be sent back-to-back with no idle gap between them.
//   clk          in  system clock
//   rst          in  synchronous active-high reset; aborts any frame
//   data_in      in  word to send, sampled on an accepted request
//   tx_ready_in  in  request; accepted when high and tx_buf_full is low
//   tx_buf_full  out holding buffer occupied, requests are dropped
//   tx_ongoing   out high from first start-bit cycle to last stop-bit cycle
//   tx_done      out one-cycle pulse on the final cycle of the last stop bit
//   data_out_tx  out serial line, idle high
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_ready_in,
    output logic                 tx_buf_full,
    output logic                 tx_ongoing,
    output logic                 tx_done,
    output logic                 data_out_tx
);

    localparam int BW = 4;  // bit counter: data bits (<=9) and stop bits
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    tx_state_t            r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_buf,   w_buf_next;
    logic                 r_buf_full, w_buf_full_next;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
    logic                 r_parity, w_parity_next;
    logic                 r_tx, w_tx_next;
    logic                 r_ongoing, w_ongoing_next;
    logic                 r_done, w_done_next;

    logic w_bit_end;
    logic w_bit_pre_end;
    logic w_accept;
    logic w_last_stop;

    // Counter is held at zero while idle so the start bit gets a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk           (clk),
        .rst           (rst),
        .i_restart     (r_state == ST_IDLE),
        .o_bit_end     (w_bit_end),
        .o_bit_pre_end (w_bit_pre_end)
    );

    assign w_accept    = tx_ready_in && !r_buf_full;
    assign w_last_stop = (r_bit_cnt == LAST_STOP);

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_buf_next      = r_buf;
        w_buf_full_next = r_buf_full;
        w_bit_cnt_next  = r_bit_cnt;
        w_parity_next   = r_parity;

        // Requests arriving mid-frame go to the holding buffer.
        if (r_state != ST_IDLE && w_accept) begin
            w_buf_next      = data_in;
            w_buf_full_next = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shift_next   = data_in;
                    w_parity_next  = (^data_in) ^ PAR_MODE;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_bit_cnt_next = '0;
                        if (r_buf_full) begin
                            // Chain the buffered word with no idle gap.
                            w_shift_next    = r_buf;
                            w_parity_next   = (^r_buf) ^ PAR_MODE;
                            w_buf_full_next = 1'b0;
                            w_state_next    = ST_START;
                        end else if (w_accept) begin
                            // A request landing on the very last cycle would
                            // otherwise strand in the buffer; send it directly.
                            w_shift_next    = data_in;
                            w_parity_next   = (^data_in) ^ PAR_MODE;
                            w_buf_full_next = 1'b0;
                            w_state_next    = ST_START;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so they can be registered.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_parity_next;
            default:   w_tx_next = 1'b1;
        endcase
        w_ongoing_next = (w_state_next != ST_IDLE);
        // Registered one cycle early so the pulse sits on the final cycle.
        w_done_next    = (r_state == ST_STOP) && w_last_stop && w_bit_pre_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ongoing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_buf      <= w_buf_next;
            r_buf_full <= w_buf_full_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_ongoing  <= w_ongoing_next;
            r_done     <= w_done_next;
        end
    end

    assign data_out_tx = r_tx;
    assign tx_ongoing  = r_ongoing;
    assign tx_done     = r_done;
    assign tx_buf_full = r_buf_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Four transmitter instances: 8N1, 8E1, 8O1 and 5N2, all at 4 clocks per bit.
// Inputs are driven and outputs sampled on the falling edge; sample k is the
// k-th cycle after the edge that accepted the first request of a sequence.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_a, req_b, req_c, req_d;
    logic [7:0] din_a, din_b, din_c;
    logic [4:0] din_d;
    logic       full_a, ong_a, done_a, line_a;
    logic       full_b, ong_b, done_b, line_b;
    logic       full_c, ong_c, done_c, line_c;
    logic       full_d, ong_d, done_d, line_d;

    uart_tx_param #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .tx_ready_in(req_a),
        .tx_buf_full(full_a), .tx_ongoing(ong_a), .tx_done(done_a), .data_out_tx(line_a));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .tx_ready_in(req_b),
        .tx_buf_full(full_b), .tx_ongoing(ong_b), .tx_done(done_b), .data_out_tx(line_b));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst(rst), .data_in(din_c), .tx_ready_in(req_c),
        .tx_buf_full(full_c), .tx_ongoing(ong_c), .tx_done(done_c), .data_out_tx(line_c));

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) dut_d (
        .clk(clk), .rst(rst), .data_in(din_d), .tx_ready_in(req_d),
        .tx_buf_full(full_d), .tx_ongoing(ong_d), .tx_done(done_d), .data_out_tx(line_d));

    int checks   = 0;
    int failures = 0;

    // Request schedule used by capture(): request sched_d[j] is driven for the
    // edge that follows sample sched_k[j]; rst is high for the edge after rst_at.
    int         sched_k [4];
    logic [8:0] sched_d [4];
    int         rst_at;

    logic [127:0] got_line, got_ong, got_done, got_full;

    typedef struct {
        int          sel;
        logic [8:0]  data;
        int          nbits;
        logic [15:0] bits;   // bit i = i-th serial bit sent (start first)
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] sample(input int sel);
        case (sel)
            0:       return {full_a, ong_a, done_a, line_a};
            1:       return {full_b, ong_b, done_b, line_b};
            2:       return {full_c, ong_c, done_c, line_c};
            default: return {full_d, ong_d, done_d, line_d};
        endcase
    endfunction

    task automatic drive(input int sel, input logic r, input logic [8:0] d);
        case (sel)
            0:       begin req_a = r; din_a = d[7:0]; end
            1:       begin req_b = r; din_b = d[7:0]; end
            2:       begin req_c = r; din_c = d[7:0]; end
            default: begin req_d = r; din_d = d[4:0]; end
        endcase
    endtask

    function automatic logic [127:0] ones(input int start, input int len);
        logic [127:0] v = '0;
        for (int i = 0; i < len; i++) v[start + i] = 1'b1;
        return v;
    endfunction

    // Idle-high line with one frame starting at sample 'start'.
    function automatic logic [127:0] line_exp(input int start, input logic [15:0] bits,
                                              input int nbits);
        logic [127:0] v = '1;
        for (int i = 0; i < nbits * CPB; i++) v[start + i] = bits[i / CPB];
        return v;
    endfunction

    function automatic logic [127:0] mask(input int n);
        return ones(1, n);
    endfunction

    task automatic clear_sched();
        for (int j = 0; j < 4; j++) begin
            sched_k[j] = -1;
            sched_d[j] = '0;
        end
        rst_at = -1;
    endtask

    // Must be entered just after a falling edge.
    task automatic capture(input int sel, input int n);
        logic [3:0] s;
        got_line = '0; got_ong = '0; got_done = '0; got_full = '0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(negedge clk);
                s = sample(sel);
                got_full[k] = s[3];
                got_ong[k]  = s[2];
                got_done[k] = s[1];
                got_line[k] = s[0];
            end
            drive(sel, 1'b0, 9'h0);
            for (int j = 0; j < 4; j++)
                if (sched_k[j] == k) drive(sel, 1'b1, sched_d[j]);
            rst = (k == rst_at);
        end
        drive(sel, 1'b0, 9'h0);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        int len;
        int n;
        len = vecs[idx].nbits * CPB;
        n   = len + 4;
        clear_sched();
        sched_k[0] = 0;
        sched_d[0] = vecs[idx].data;
        capture(vecs[idx].sel, n);
        $display("vec %0d sel=%0d data=%h line=%h", idx, vecs[idx].sel, vecs[idx].data, got_line & mask(n));
        chk($sformatf("vec%0d_line", idx), got_line & mask(n), line_exp(1, vecs[idx].bits, vecs[idx].nbits) & mask(n));
        chk($sformatf("vec%0d_ongoing", idx), got_ong & mask(n), ones(1, len));
        chk($sformatf("vec%0d_done", idx), got_done & mask(n), ones(len, 1));
        chk($sformatf("vec%0d_full", idx), got_full & mask(n), '0);
    endtask

    initial begin
        logic [127:0] e_line;
        logic [3:0]   s;
        int           n;

        rst = 1'b1;
        req_a = 0; req_b = 0; req_c = 0; req_d = 0;
        din_a = 0; din_b = 0; din_c = 0; din_d = 0;

        vecs[0] = '{0, 9'h0B7, frame_len(8, 0, 1), 16'({1'b1, 8'hB7, 1'b0})};
        vecs[1] = '{0, 9'h000, frame_len(8, 0, 1), 16'({1'b1, 8'h00, 1'b0})};
        vecs[2] = '{0, 9'h0FF, frame_len(8, 0, 1), 16'({1'b1, 8'hFF, 1'b0})};
        vecs[3] = '{1, 9'h0B7, frame_len(8, 1, 1), 16'({1'b1, 1'b0, 8'hB7, 1'b0})};
        vecs[4] = '{2, 9'h0B7, frame_len(8, 1, 1), 16'({1'b1, 1'b1, 8'hB7, 1'b0})};
        vecs[5] = '{1, 9'h001, frame_len(8, 1, 1), 16'({1'b1, 1'b1, 8'h01, 1'b0})};
        vecs[6] = '{3, 9'h01A, frame_len(5, 0, 2), 16'({2'b11, 5'h1A, 1'b0})};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        for (int sel = 0; sel < 4; sel++) begin
            s = sample(sel);
            $display("reset sel=%0d full=%b ong=%b done=%b line=%b", sel, s[3], s[2], s[1], s[0]);
            chk($sformatf("reset_sel%0d", sel), {124'h0, s}, {124'h0, 4'b0001});
        end

        // Single frames across configurations
        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back: 55 then A3 two cycles later, no idle gap
        clear_sched();
        sched_k[0] = 0; sched_d[0] = 9'h055;
        sched_k[1] = 2; sched_d[1] = 9'h0A3;
        n = 85;
        capture(0, n);
        $display("b2b line=%h full=%h done=%h", got_line & mask(n), got_full & mask(n), got_done & mask(n));
        e_line = line_exp(1, 16'({1'b1, 8'h55, 1'b0}), 10) & line_exp(41, 16'({1'b1, 8'hA3, 1'b0}), 10);
        chk("b2b_line", got_line & mask(n), e_line & mask(n));
        chk("b2b_ongoing", got_ong & mask(n), ones(1, 80));
        chk("b2b_done", got_done & mask(n), ones(40, 1) | ones(80, 1));
        chk("b2b_full", got_full & mask(n), ones(3, 38));

        // Overflow: 33 requested while the buffer holds 22 is dropped
        clear_sched();
        sched_k[0] = 0; sched_d[0] = 9'h011;
        sched_k[1] = 2; sched_d[1] = 9'h022;
        sched_k[2] = 5; sched_d[2] = 9'h033;
        n = 90;
        capture(0, n);
        $display("ovf line=%h full=%h done=%h", got_line & mask(n), got_full & mask(n), got_done & mask(n));
        e_line = line_exp(1, 16'({1'b1, 8'h11, 1'b0}), 10) & line_exp(41, 16'({1'b1, 8'h22, 1'b0}), 10);
        chk("ovf_line", got_line & mask(n), e_line & mask(n));
        chk("ovf_ongoing", got_ong & mask(n), ones(1, 80));
        chk("ovf_done", got_done & mask(n), ones(40, 1) | ones(80, 1));
        chk("ovf_full", got_full & mask(n), ones(3, 38));

        // Reset during data bit 3 (samples 17..20) with a word buffered
        clear_sched();
        sched_k[0] = 0; sched_d[0] = 9'h0B7;
        sched_k[1] = 2; sched_d[1] = 9'h022;
        rst_at = 18;
        n = 60;
        capture(0, n);
        $display("rst line=%h ong=%h full=%h done=%h", got_line & mask(n), got_ong & mask(n), got_full & mask(n), got_done & mask(n));
        e_line = line_exp(1, 16'({1'b1, 8'hB7, 1'b0}), 10) | ones(19, 42);
        chk("rst_line", got_line & mask(n), e_line & mask(n));
        chk("rst_ongoing", got_ong & mask(n), ones(1, 18));
        chk("rst_done", got_done & mask(n), '0);
        chk("rst_full", got_full & mask(n), ones(3, 16));

        // Complete frame after the aborted one
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
